// File: rtl/rssi_ctrl_pkg.sv
// Shared constants and types for the RSSI measurement sequencer.
// Build option: RSSI_THRESH_IRQ_EN enables THRESH/IRQ_EN/THR/irq.
package rssi_ctrl_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_SUM_W = 27;

    localparam logic [11:0] OFF_CTRL   = 12'h000;
    localparam logic [11:0] OFF_WINLEN = 12'h004;
    localparam logic [11:0] OFF_STATUS = 12'h008;
    localparam logic [11:0] OFF_RESULT = 12'h00C;
    localparam logic [11:0] OFF_THRESH = 12'h010;
    localparam logic [11:0] OFF_IRQ_EN = 12'h014;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;

    localparam int ST_DONE = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_OVR  = 2;
    localparam int ST_THR  = 3;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_CLEAR   = 3'd1;
    localparam state_t S_ACCUM   = 3'd2;
    localparam state_t S_SETTLE  = 3'd3;
    localparam state_t S_CAPTURE = 3'd4;

endpackage

// File: rtl/rssi_apb_if.sv
// APB slave bundle for the RSSI measurement sequencer.
// Word-addressed (PADDR[11:2]), zero wait state.
interface rssi_apb_if;

    logic        PSEL;
    logic [11:2] PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/rssi_ctrl_regs.sv
// APB decode, register file and sticky status flags.
// Build option: RSSI_THRESH_IRQ_EN adds THRESH, IRQ_EN and irq.
module rssi_ctrl_regs
    import rssi_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int SUM_W = DEF_SUM_W
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    rssi_apb_if.slave        apb,
    input  logic             busy,
    input  logic             cap,
    input  logic             thr_hit,
    input  logic [SUM_W-1:0] result,
    output logic             start,
    output logic             en,
    output logic             cont,
    output logic [CNT_W-1:0] winlen,
    output logic [SUM_W-1:0] thresh,
    output logic             irq
);

    logic        wr;
    logic        setup_rd;
    logic [31:0] wdata;
    logic        sel_ctrl, sel_win, sel_stat;
    logic        sel_res, sel_thr, sel_ien;
    logic        mapped;
    logic        w1c;

    logic             en_q, cont_q;
    logic [CNT_W-1:0] winlen_q;
    logic             done_q, ovr_q, thr_q, irq_q;
    logic             done_n, ovr_n, thr_n, irq_n;
    logic [31:0]      rdata, prdata_q;
    logic             unused_bits;

    assign wr       = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign setup_rd = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
    assign wdata    = apb.PWDATA;

    assign sel_ctrl = apb.PADDR == OFF_CTRL[11:2];
    assign sel_win  = apb.PADDR == OFF_WINLEN[11:2];
    assign sel_stat = apb.PADDR == OFF_STATUS[11:2];
    assign sel_res  = apb.PADDR == OFF_RESULT[11:2];
    assign sel_thr  = apb.PADDR == OFF_THRESH[11:2];
    assign sel_ien  = apb.PADDR == OFF_IRQ_EN[11:2];
    assign mapped   = sel_ctrl | sel_win | sel_stat
                    | sel_res | sel_thr | sel_ien;

    assign unused_bits = ^wdata;

    // Control and start are seen by the FSM in the write cycle itself
    assign en    = (wr & sel_ctrl) ? wdata[CTRL_EN] : en_q;
    assign cont  = (wr & sel_ctrl) ? wdata[CTRL_CONT] : cont_q;
    assign start = wr & sel_ctrl
                 & wdata[CTRL_START] & wdata[CTRL_EN];

    assign winlen = winlen_q;

    // Capture-side set wins over a same-cycle software clear
    assign w1c    = wr & sel_stat;
    assign done_n = cap
                  | (done_q & ~(w1c & wdata[ST_DONE]));
    assign ovr_n  = (cap & done_q)
                  | (ovr_q & ~(w1c & wdata[ST_OVR]));
    assign thr_n  = thr_hit
                  | (thr_q & ~(w1c & wdata[ST_THR]));

`ifdef RSSI_THRESH_IRQ_EN
    logic [SUM_W-1:0] thresh_q;
    logic             ien_q;
    logic             ien_n;

    assign ien_n  = (wr & sel_ien) ? wdata[0] : ien_q;
    assign irq_n  = ien_n & (done_n | thr_n);
    assign thresh = thresh_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            thresh_q <= '0;
            ien_q    <= 1'b0;
        end else begin
            if (wr & sel_thr) thresh_q <= wdata[SUM_W-1:0];
            ien_q <= ien_n;
        end
    end
`else
    assign irq_n  = 1'b0;
    assign thresh = '0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            en_q     <= 1'b0;
            cont_q   <= 1'b0;
            winlen_q <= '0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            thr_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            en_q   <= en;
            cont_q <= cont;
            if (wr & sel_win) winlen_q <= wdata[CNT_W-1:0];
            done_q <= done_n;
            ovr_q  <= ovr_n;
            thr_q  <= thr_n;
            irq_q  <= irq_n;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            sel_ctrl: rdata[1:0] = {cont_q, en_q};
            sel_win:  rdata[CNT_W-1:0] = winlen_q;
            sel_stat: rdata[3:0] = {thr_q, ovr_q, busy, done_q};
            sel_res:  rdata[SUM_W-1:0] = result;
            sel_thr:  rdata[SUM_W-1:0] = thresh;
`ifdef RSSI_THRESH_IRQ_EN
            sel_ien:  rdata[0] = ien_q;
`endif
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) prdata_q <= '0;
        else if (setup_rd) prdata_q <= rdata;
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = apb.PSEL & apb.PENABLE & ~mapped;
    assign irq         = irq_q;

endmodule

// File: rtl/rssi_meas_ctrl.sv
// RSSI measurement sequencer: window FSM, sample counter, capture.
// Build option: RSSI_THRESH_IRQ_EN enables the threshold flag and irq.
module rssi_meas_ctrl
    import rssi_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int SUM_W = DEF_SUM_W
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    rssi_apb_if.slave        apb,
    input  logic             sample_valid,
    input  logic [SUM_W-1:0] rssi_sum,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             irq
);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt_q, win_q, cnt_inc, winlen;
    logic [SUM_W-1:0] result_q, thresh;
    logic             start, en, cont;
    logic             cap, thr_hit, busy, last;

    rssi_ctrl_regs #(
        .CNT_W (CNT_W),
        .SUM_W (SUM_W)
    ) u_regs (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .apb     (apb),
        .busy    (busy),
        .cap     (cap),
        .thr_hit (thr_hit),
        .result  (result_q),
        .start   (start),
        .en      (en),
        .cont    (cont),
        .winlen  (winlen),
        .thresh  (thresh),
        .irq     (irq)
    );

    assign busy    = state != S_IDLE;
    assign acc_clr = state == S_CLEAR;
    assign acc_en  = state == S_ACCUM;
    assign cap     = (state == S_CAPTURE) & en;
    assign cnt_inc = cnt_q + 1'b1;
    assign last    = sample_valid & (cnt_inc == win_q);

`ifdef RSSI_THRESH_IRQ_EN
    logic [SUM_W-1:0] thr_lat;

    assign thr_hit = cap & (rssi_sum >= thr_lat);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) thr_lat <= '0;
        else if (state == S_CLEAR) thr_lat <= thresh;
    end
`else
    logic unused_thresh;

    assign thr_hit       = 1'b0;
    assign unused_thresh = ^thresh;
`endif

    // Clearing EN aborts from any state, without capturing
    always_comb begin
        state_n = state;
        if (!en) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start) state_n = S_CLEAR;
                S_CLEAR:   state_n = S_ACCUM;
                S_ACCUM:   if (last) state_n = S_SETTLE;
                S_SETTLE:  state_n = S_CAPTURE;
                S_CAPTURE: state_n = cont ? S_CLEAR : S_IDLE;
                default:   state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= S_IDLE;
            cnt_q    <= '0;
            win_q    <= '0;
            result_q <= '0;
        end else begin
            state <= state_n;
            if (state == S_CLEAR) begin
                cnt_q <= '0;
                win_q <= (winlen == '0) ? CNT_W'(1) : winlen;
            end else if (acc_en & sample_valid) begin
                cnt_q <= cnt_inc;
            end
            if (cap) result_q <= rssi_sum;
        end
    end

endmodule

// File: tb/tb_rssi_meas_ctrl.sv
// Self-checking bench for rssi_meas_ctrl: APB register access,
// one-shot/continuous windows, abort, bus error, async reset.
module tb_rssi_meas_ctrl;

    localparam logic [11:0] A_CTRL = 12'h000;
    localparam logic [11:0] A_WIN  = 12'h004;
    localparam logic [11:0] A_STAT = 12'h008;
    localparam logic [11:0] A_RES  = 12'h00C;
    localparam logic [11:0] A_THR  = 12'h010;
    localparam logic [11:0] A_IEN  = 12'h014;
    localparam logic [11:0] A_BAD  = 12'h040;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        sample_valid;
    logic [26:0] rssi_sum;
    logic        acc_clr, acc_en, irq;
    logic        err;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    rssi_apb_if apb ();

    rssi_meas_ctrl #(
        .CNT_W (16),
        .SUM_W (27)
    ) dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .apb          (apb),
        .sample_valid (sample_valid),
        .rssi_sum     (rssi_sum),
        .acc_clr      (acc_clr),
        .acc_en       (acc_en),
        .irq          (irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic wr(input logic [11:0] off, input logic [31:0] d);
        apb.PSEL    = 1'b1;
        apb.PWRITE  = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PADDR   = off[11:2];
        apb.PWDATA  = d;
        step(1);
        apb.PENABLE = 1'b1;
        #1 err = apb.PSLVERR;
        step(1);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
    endtask

    task automatic rd(input logic [11:0] off, input logic [31:0] exp,
                      input string tag, input logic err_exp = 1'b0);
        logic [31:0] got;
        exp_q.push_back(exp);
        apb.PSEL    = 1'b1;
        apb.PWRITE  = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PADDR   = off[11:2];
        step(1);
        apb.PENABLE = 1'b1;
        #1 got = apb.PRDATA;
        chk(tag, got, exp_q.pop_front());
        chk({tag, "_slverr"}, 32'(apb.PSLVERR), 32'(err_exp));
        step(1);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    task automatic pulse(input logic [26:0] sum);
        sample_valid = 1'b1;
        rssi_sum     = sum;
        step(1);
        sample_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        apb.PSEL     = 1'b0;
        apb.PENABLE  = 1'b0;
        apb.PWRITE   = 1'b0;
        apb.PADDR    = '0;
        apb.PWDATA   = '0;
        sample_valid = 1'b0;
        rssi_sum     = '0;
        err          = 1'b0;

        #13;
        chk("rst_pready", 32'(apb.PREADY), 32'd1);
        chk("rst_prdata", apb.PRDATA, 32'd0);
        #10 PRESETn = 1'b1;
        step(1);
        chk("rst_acc_en", 32'(acc_en), 32'd0);
        chk("rst_acc_clr", 32'(acc_clr), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rd(A_CTRL, 32'd0, "rst_ctrl");
        rd(A_WIN, 32'd0, "rst_winlen");
        rd(A_STAT, 32'd0, "rst_status");
        rd(A_RES, 32'd0, "rst_result");
        rd(A_THR, 32'd0, "rst_thresh");
        rd(A_IEN, 32'd0, "rst_irq_en");

        // one-shot window of 4 samples
        wr(A_WIN, 32'd4);
        wr(A_CTRL, 32'h5);
        chk("os_clr", 32'(acc_clr), 32'd1);
        chk("os_en_in_clr", 32'(acc_en), 32'd0);
        step(1);
        chk("os_en", 32'(acc_en), 32'd1);
        chk("os_clr_done", 32'(acc_clr), 32'd0);
        repeat (4) pulse(27'd1000);
        chk("os_en_drop", 32'(acc_en), 32'd0);
        rd(A_STAT, 32'h2, "os_stat_busy");
        rd(A_RES, 32'd1000, "os_result");
        rd(A_STAT, 32'h1, "os_stat_done");
        rd(A_CTRL, 32'h1, "os_ctrl");

        // continuous mode, second capture overflows DONE
        wr(A_STAT, 32'h1);
        wr(A_WIN, 32'd2);
        wr(A_CTRL, 32'h7);
        step(1);
        repeat (2) pulse(27'd200);
        chk("ct_dead_en", 32'(acc_en), 32'd0);
        step(1);
        pulse(27'd200);
        chk("ct_reclear", 32'(acc_clr), 32'd1);
        step(1);
        pulse(27'd300);
        chk("ct_dead_not_cnt", 32'(acc_en), 32'd1);
        pulse(27'd300);
        step(2);
        rd(A_STAT, 32'h7, "ct_stat_ovr");
        rd(A_RES, 32'd300, "ct_result");
        rd(A_CTRL, 32'h3, "ct_ctrl");
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h5);
        rd(A_STAT, 32'h0, "ct_w1c");

        // abort mid-window
        wr(A_WIN, 32'd3);
        wr(A_CTRL, 32'h5);
        step(1);
        pulse(27'd777);
        wr(A_CTRL, 32'h0);
        chk("ab_en_drop", 32'(acc_en), 32'd0);
        rd(A_RES, 32'd300, "ab_result");
        rd(A_STAT, 32'h0, "ab_status");

        // START without EN is ignored
        wr(A_CTRL, 32'h4);
        chk("noen_clr", 32'(acc_clr), 32'd0);
        rd(A_STAT, 32'h0, "noen_status");

        // unmapped access
        rd(A_BAD, 32'd0, "bad_rd", 1'b1);
        wr(A_BAD, 32'hFFFF_FFFF);
        chk("bad_wr_slverr", 32'(err), 32'd1);
        rd(A_WIN, 32'd3, "bad_wr_win");
        rd(A_CTRL, 32'd0, "bad_wr_ctrl");

`ifdef RSSI_THRESH_IRQ_EN
        wr(A_THR, 32'd500);
        wr(A_IEN, 32'd1);
        wr(A_WIN, 32'd1);
        wr(A_CTRL, 32'h5);
        step(1);
        pulse(27'd600);
        chk("th_irq_s1", 32'(irq), 32'd0);
        step(1);
        chk("th_irq_s2", 32'(irq), 32'd0);
        step(1);
        chk("th_irq_s3", 32'(irq), 32'd1);
        rd(A_STAT, 32'h9, "th_stat");
        wr(A_STAT, 32'h9);
        chk("th_irq_clr", 32'(irq), 32'd0);
        wr(A_CTRL, 32'h5);
        step(1);
        pulse(27'd400);
        step(2);
        chk("th_irq_done", 32'(irq), 32'd1);
        rd(A_STAT, 32'h1, "th_below");
        rd(A_RES, 32'd400, "th_result");
        wr(A_STAT, 32'hF);
`else
        wr(A_THR, 32'd500);
        wr(A_IEN, 32'd1);
        chk("nt_thr_slverr", 32'(err), 32'd0);
        rd(A_THR, 32'd0, "nt_thresh");
        rd(A_IEN, 32'd0, "nt_irq_en");
        wr(A_WIN, 32'd1);
        wr(A_CTRL, 32'h5);
        step(1);
        pulse(27'd600);
        step(2);
        chk("nt_irq", 32'(irq), 32'd0);
        rd(A_STAT, 32'h1, "nt_status");
        rd(A_RES, 32'd600, "nt_result");
        wr(A_STAT, 32'hF);
`endif

        // asynchronous reset mid-window
        wr(A_WIN, 32'd5);
        wr(A_CTRL, 32'h5);
        step(1);
        pulse(27'd10);
        chk("ar_en_pre", 32'(acc_en), 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        chk("ar_acc_en", 32'(acc_en), 32'd0);
        chk("ar_acc_clr", 32'(acc_clr), 32'd0);
        chk("ar_irq", 32'(irq), 32'd0);
        chk("ar_prdata", apb.PRDATA, 32'd0);
        #3 PRESETn = 1'b1;
        step(1);
        rd(A_CTRL, 32'd0, "ar_ctrl");
        rd(A_WIN, 32'd0, "ar_winlen");
        rd(A_RES, 32'd0, "ar_result");
        rd(A_STAT, 32'd0, "ar_status");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
